fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Parametrised successor to the single-register fetch stage. It sits between the instruction memory and decode.
- Owns the fetch PC and issues pipelined requests to imem over a valid/ready handshake.
- Buffers returned instructions in a DEPTH-entry queue, each tagged with its PC, and presents them to decode over a valid/ready handshake.
- Flushes all buffered and in-flight fetches on a redirect from execute (taken branch or jump).

Parameters:
ADDR_W, 22, width of imem_addr; the low ADDR_W bits of the fetch PC.
DEPTH, 4, instruction queue entries; power of two, 2..16.
MAX_OUTST, 2, maximum imem requests in flight; 1..DEPTH.
RESET_PC, 32'h0000_0000, fetch PC loaded at reset.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
imem_req_valid  out  1  request to imem is valid.
imem_req_ready  in  1  imem accepts the request this cycle.
imem_addr  out  ADDR_W  request address, equal to fetch_pc[ADDR_W-1:0].
imem_rsp_valid  in  1  response data valid; responses arrive in order, at least 1 cycle after acceptance.
imem_rsp_data  in  32  little-endian instruction word.
redirect_valid  in  1  flush and restart fetch at redirect_pc.
redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and treated as 0.
instr_valid  out  1  queue head is valid.
instr_ready  in  1  decode consumes the head this cycle.
instruction  out  32  big-endian, byte-swapped head instruction.
instr_pc  out  32  PC of the head instruction.

Behaviour:
- Reset values: fetch_pc=RESET_PC, rsp_pc=RESET_PC; queue empty; outstanding=0, drop_cnt=0; imem_req_valid=0, instr_valid=0, instruction=0, instr_pc=0.
- Request issue. imem_req_valid is asserted when all of the following hold:
  - !redirect_valid
  - outstanding < MAX_OUTST
  - queue_count + outstanding < DEPTH, so space is reserved for every response
  - drop_cnt == 0
- Request handshake (valid && ready): fetch_pc += 4, outstanding += 1. imem_addr is held stable while valid && !ready.
- Response, drop_cnt > 0: the data is discarded, drop_cnt -= 1, outstanding -= 1.
- Response, drop_cnt == 0: push {d[7:0],d[15:8],d[23:16],d[31:24]} tagged with rsp_pc; then rsp_pc += 4, outstanding -= 1.
- Simultaneous request accept and response: outstanding is unchanged.
- A push never overflows because of the credit rule; a push while full is an assertion failure.
- Decode side:
  - instr_valid = queue not empty; instruction and instr_pc come from the head entry.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle is legal in any state, including full; the count is unchanged.
- Redirect (registered effect at the edge where redirect_valid=1). It has priority over everything:
  - The queue is flushed; any pop that cycle is void.
  - fetch_pc and rsp_pc are loaded with {redirect_pc[31:2],2'b00}.
  - drop_cnt <= outstanding − (response this cycle ? 1 : 0). A response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle.
  - Requests resume once drop_cnt reaches 0, i.e. after all stale responses have drained.
- instr_valid deasserts the cycle after a redirect. The first new instruction is visible at least 2 cycles after the redirect edge.
- PC arithmetic is 32-bit modulo; 0xFFFF_FFFC + 4 wraps to 0.
- Reset asserted mid-operation clears all state immediately. Responses for requests issued before reset are the memory's responsibility and must not arrive after reset.

Optional Feature:
FETCH_PERF_EN:
- Defined: adds output ports perf_stall_cnt[31:0] and perf_redirect_cnt[31:0], both 0 at reset and saturating at 0xFFFF_FFFF.
  - perf_stall_cnt increments each cycle with instr_ready=1 && instr_valid=0.
  - perf_redirect_cnt increments on each redirect_valid cycle.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fetch_pkg: INSTR_W=32, PC_W=32, PC_STEP=4, and the byte-swap function bswap32.
- One sub-module, fetch_fifo: a synchronous FIFO of DEPTH × (INSTR_W+PC_W) entries with push, pop, and synchronous flush. It exposes count, full and empty, and supports simultaneous push/pop.
- fetch_queue holds the PC registers, the outstanding/drop counters and the issue logic.

Test Plan:
1. Reset, imem 1-cycle latency, instr_ready=1. Required: addresses 0,4,8,... issued back-to-back; instr_pc 0,4,8 in order; imem_rsp_data 0x78563412 → instruction 0x12345678.
2. instr_ready=0, DEPTH=4. Required: exactly 4 instructions buffered; imem_req_valid=0 while queue_count+outstanding=4; raising instr_ready drains PCs 0..12 in order.
3. imem latency 3 with 2 requests outstanding, redirect to 0x100. Required: both stale responses dropped; next imem_addr=0x100; first instr_pc=0x100; no stale instruction ever visible.
4. imem_req_ready=0 for 5 cycles. Required: imem_addr stable and imem_req_valid held; no PC advance.
5. Redirect in the same cycle as a response and a pop. Required: the response is discarded, the queue is empty next cycle, drop_cnt=outstanding−1.
6. Redirect to 0xFFFF_FFFC. Required: the next fetch wraps to 0x0000_0000. With FETCH_PERF_EN defined: perf_redirect_cnt=1, and perf_stall_cnt counts the empty cycles.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, queue entry layout and byte-swap helper for the fetch queue.
package fetch_pkg;

    localparam int          INSTR_W = 32;
    localparam int          PC_W    = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    function automatic logic [INSTR_W-1:0] bswap32(input logic [INSTR_W-1:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry instruction/PC FIFO with synchronous flush and same-cycle push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  fetch_entry_t           i_data,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/fetch_queue.sv
// Pipelined fetch stage: PC/credit bookkeeping, imem issue, redirect flush.
// Optional FETCH_PERF_EN adds stall and redirect performance counters.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          ADDR_W    = 22,
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [PC_W-1:0]    instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_redirect_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]  r_fetch_pc;
    logic [PC_W-1:0]  r_rsp_pc;
    logic [CNT_W-1:0] r_outst;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [PC_W-1:0]  w_redirect_pc;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W:0]   w_credit;
    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    fetch_entry_t     w_in_entry;
    fetch_entry_t     w_head;

    assign w_redirect_pc = redirect_pc & ~32'h3;

    // Every in-flight request owns a queue slot, so a response can always be pushed.
    assign w_credit = (CNT_W+1)'(w_count) + (CNT_W+1)'(r_outst);

    assign imem_req_valid = !reset && !redirect_valid
                         && (r_outst < CNT_W'(MAX_OUTST))
                         && (w_credit < (CNT_W+1)'(DEPTH))
                         && (r_drop_cnt == '0);
    assign imem_addr      = r_fetch_pc[ADDR_W-1:0];

    assign w_accept = imem_req_valid && imem_req_ready;
    assign w_push   = imem_rsp_valid && !redirect_valid && (r_drop_cnt == '0);
    assign w_pop    = instr_valid && instr_ready && !redirect_valid;

    assign w_in_entry.instr = bswap32(imem_rsp_data);
    assign w_in_entry.pc    = r_rsp_pc;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_in_entry),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign instr_valid = !w_empty;
    assign instruction = w_empty ? '0 : w_head.instr;
    assign instr_pc    = w_empty ? '0 : w_head.pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_outst    <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_outst <= r_outst + CNT_W'(w_accept) - CNT_W'(imem_rsp_valid);
            if (redirect_valid) begin
                // Everything still in flight is stale; a response landing now is already discarded.
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_drop_cnt <= r_outst - CNT_W'(imem_rsp_valid);
            end else begin
                if (w_accept) r_fetch_pc <= r_fetch_pc + PC_STEP;
                if (w_push)   r_rsp_pc   <= r_rsp_pc + PC_STEP;
                if (imem_rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset) assert (!(w_push && w_full && !w_pop));
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_stall    <= '0;
            r_perf_redirect <= '0;
        end else begin
            if (instr_ready && !instr_valid && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 1'b1;
            if (redirect_valid && (r_perf_redirect != '1))
                r_perf_redirect <= r_perf_redirect + 1'b1;
        end
    end

    assign perf_stall_cnt    = r_perf_stall;
    assign perf_redirect_cnt = r_perf_redirect;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order, fixed-latency imem responder.
`timescale 1ns/1ps
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [21:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_redirect_cnt;
`endif

    fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    int          lat = 1;
    int          cyc = 0;
    int          ncyc = 0;
    int          stall_seen = 0;
    logic        s_acc = 1'b0;
    logic        s_rspv = 1'b0;
    logic [21:0] s_addr = '0;
    logic [21:0] pend_addr[$];
    int          pend_due[$];
    logic [21:0] acc_log[$];
    int          acc_cyc[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_ins[$];

    // Memory contents: byte-reversed (addr ^ 0x12345678), so decode sees addr ^ 0x12345678.
    function automatic logic [31:0] mem_data(input logic [21:0] a);
        logic [31:0] w;
        w = {10'b0, a} ^ 32'h1234_5678;
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    always @(negedge clk) begin
        ncyc++;
        s_acc  = !reset && imem_req_valid && imem_req_ready;
        s_addr = imem_addr;
        s_rspv = !reset && imem_rsp_valid;
        if (s_acc) begin
            acc_log.push_back(imem_addr);
            acc_cyc.push_back(ncyc);
        end
        if (!reset && instr_valid && instr_ready && !redirect_valid) begin
            pop_pc.push_back(instr_pc);
            pop_ins.push_back(instruction);
        end
        if (!reset && instr_ready && !instr_valid) stall_seen++;
    end

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            pend_addr.delete();
            pend_due.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end else begin
            if (s_rspv && pend_addr.size() > 0) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (s_acc) begin
                pend_addr.push_back(s_addr);
                pend_due.push_back(cyc + lat - 1);
            end
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_data(pend_addr[0]);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'h0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_log.delete();
        acc_cyc.delete();
        pop_pc.delete();
        pop_ins.delete();
    endtask

    task automatic do_reset(input logic rdy, input int latency, input logic rrdy);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = rdy;
        imem_req_ready = rrdy;
        lat            = latency;
        tick();
        tick();
        clear_logs();
        stall_seen = 0;
        @(negedge clk);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_instruction", instruction, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int lim);
        int k = 0;
        while (acc_log.size() < n && k < lim) begin
            tick();
            k++;
        end
        check("acc_count", (acc_log.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_pop(input int n, input int lim);
        int k = 0;
        while (pop_pc.size() < n && k < lim) begin
            tick();
            k++;
        end
        check("pop_count", (pop_pc.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        // 1: streaming with 1-cycle imem
        do_reset(1'b1, 1, 1'b1);
        @(negedge clk);
        check("t1_first_valid", {31'b0, imem_req_valid}, 32'h1);
        check("t1_first_addr", {10'b0, imem_addr}, 32'h0);
        tick();
        wait_acc(5, 20);
        wait_pop(3, 20);
        check("t1_addr0", {10'b0, acc_log[0]}, 32'h0);
        check("t1_addr1", {10'b0, acc_log[1]}, 32'h4);
        check("t1_addr2", {10'b0, acc_log[2]}, 32'h8);
        check("t1_addr3", {10'b0, acc_log[3]}, 32'hC);
        for (int i = 0; i < 3; i++)
            check("t1_b2b", acc_cyc[i+1] - acc_cyc[i], 32'd1);
        check("t1_pc0", pop_pc[0], 32'h0);
        check("t1_pc1", pop_pc[1], 32'h4);
        check("t1_pc2", pop_pc[2], 32'h8);
        check("t1_ins0", pop_ins[0], 32'h1234_5678);
        check("t1_ins1", pop_ins[1], 32'h1234_567C);

        // 2: decode stalled, queue fills to DEPTH
        do_reset(1'b0, 1, 1'b1);
        repeat (12) tick();
        @(negedge clk);
        check("t2_acc_total", acc_log.size(), 32'd4);
        check("t2_req_blocked", {31'b0, imem_req_valid}, 32'h0);
        check("t2_head_valid", {31'b0, instr_valid}, 32'h1);
        check("t2_head_pc", instr_pc, 32'h0);
        check("t2_head_ins", instruction, 32'h1234_5678);
        tick();
        instr_ready = 1'b1;
        wait_pop(4, 20);
        check("t2_pc0", pop_pc[0], 32'h0);
        check("t2_pc1", pop_pc[1], 32'h4);
        check("t2_pc2", pop_pc[2], 32'h8);
        check("t2_pc3", pop_pc[3], 32'hC);
        check("t2_ins3", pop_ins[3], 32'h1234_5674);
        wait_acc(5, 20);
        check("t2_addr4", {10'b0, acc_log[4]}, 32'h10);

        // 3: redirect with two stale requests in flight (latency 3)
        do_reset(1'b1, 3, 1'b1);
        wait_acc(2, 10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0101;
        clear_logs();
        @(negedge clk);
        check("t3_no_req_in_redirect", {31'b0, imem_req_valid}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t3_empty_after", {31'b0, instr_valid}, 32'h0);
        check("t3_held_while_drain", {31'b0, imem_req_valid}, 32'h0);
        tick();
        wait_acc(1, 20);
        check("t3_addr_new", {10'b0, acc_log[0]}, 32'h100);
        wait_pop(2, 30);
        check("t3_pc0", pop_pc[0], 32'h100);
        check("t3_ins0", pop_ins[0], 32'h1234_5778);
        check("t3_pc1", pop_pc[1], 32'h104);

        // 4: imem back-pressure holds the request
        do_reset(1'b1, 1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_valid_held", {31'b0, imem_req_valid}, 32'h1);
            check("t4_addr_stable", {10'b0, imem_addr}, 32'h0);
            tick();
        end
        imem_req_ready = 1'b1;
        wait_acc(3, 20);
        check("t4_addr0", {10'b0, acc_log[0]}, 32'h0);
        check("t4_addr1", {10'b0, acc_log[1]}, 32'h4);
        check("t4_addr2", {10'b0, acc_log[2]}, 32'h8);

        // 5: redirect together with a response and a pop
        do_reset(1'b1, 1, 1'b1);
        repeat (6) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        clear_logs();
        @(negedge clk);
        check("t5_rsp_in_redirect", {31'b0, imem_rsp_valid}, 32'h1);
        check("t5_pop_in_redirect", {31'b0, instr_valid}, 32'h1);
        check("t5_no_req_in_redirect", {31'b0, imem_req_valid}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t5_empty_next", {31'b0, instr_valid}, 32'h0);
        check("t5_req_resumes", {31'b0, imem_req_valid}, 32'h1);
        check("t5_addr", {10'b0, imem_addr}, 32'h200);
        tick();
        wait_pop(1, 20);
        check("t5_pc0", pop_pc[0], 32'h200);

        // 6: redirect to the top of the address space wraps
        do_reset(1'b1, 1, 1'b1);
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        clear_logs();
        tick();
        redirect_valid = 1'b0;
        wait_acc(2, 20);
        check("t6_addr0", {10'b0, acc_log[0]}, 32'h003F_FFFC);
        check("t6_addr1", {10'b0, acc_log[1]}, 32'h0);
        wait_pop(2, 20);
        check("t6_pc0", pop_pc[0], 32'hFFFF_FFFC);
        check("t6_pc1", pop_pc[1], 32'h0000_0000);
`ifdef FETCH_PERF_EN
        check("t6_perf_redirect", perf_redirect_cnt, 32'd1);
        check("t6_perf_stall", perf_stall_cnt, stall_seen);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
